// File: rtl/load_store_unit.sv
// Load/store unit: turns pipeline load/store requests into single data-bus transactions,
// with alignment checking, byte-lane steering and a bus timeout.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [31:0] ALU_value,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        load_byte,
    input  logic        store_byte,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] memory_value,
    output logic        stall,
    output logic        mem_error
);
    // state | meaning
    // IDLE  | accept a request; legal ones launch a bus access, bad ones flag an error
    // WAIT  | bus strobe asserted, waiting for ack or timeout
    // DONE  | one-cycle completion slot, stall released, held request ignored
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic        byte_q, byte_q_nxt;
    logic [1:0]  lane_q, lane_q_nxt;
    logic [31:0] bus_addr_nxt, bus_wdata_nxt, memory_value_nxt;
    logic [3:0]  bus_sel_nxt;
    logic        bus_read_nxt, bus_write_nxt, mem_error_nxt;

    logic        req, is_word, legal;
    logic [3:0]  lane_sel;
    logic [7:0]  lane_byte;

    always_comb begin
        req      = mem_read | mem_write;
        is_word  = mem_read ? ~load_byte : ~store_byte;
        legal    = (mem_read ^ mem_write) && (!is_word || ALU_value[1:0] == 2'b00);
        lane_sel = 4'b0001 << ALU_value[1:0];
        case (lane_q)
            2'd0:    lane_byte = bus_rdata[7:0];
            2'd1:    lane_byte = bus_rdata[15:8];
            2'd2:    lane_byte = bus_rdata[23:16];
            default: lane_byte = bus_rdata[31:24];
        endcase
    end

    always_comb begin
        state_nxt        = state;
        wait_cnt_nxt     = wait_cnt;
        byte_q_nxt       = byte_q;
        lane_q_nxt       = lane_q;
        bus_addr_nxt     = bus_addr;
        bus_wdata_nxt    = bus_wdata;
        bus_sel_nxt      = bus_sel;
        bus_read_nxt     = bus_read;
        bus_write_nxt    = bus_write;
        memory_value_nxt = memory_value;
        mem_error_nxt    = 1'b0;
        stall            = 1'b0;

        case (state)
            IDLE: begin
                stall = req;
                if (req) begin
                    if (legal) begin
                        bus_read_nxt  = mem_read;
                        bus_write_nxt = mem_write;
                        bus_addr_nxt  = {ALU_value[31:2], 2'b00};
                        bus_sel_nxt   = is_word ? 4'b1111 : lane_sel;
                        if (mem_write)
                            bus_wdata_nxt = store_byte ? {4{store_data[7:0]}} : store_data;
                        else
                            bus_wdata_nxt = 32'h0;
                        byte_q_nxt    = ~is_word;
                        lane_q_nxt    = ALU_value[1:0];
                        wait_cnt_nxt  = 16'h0;
                        state_nxt     = WAIT;
                    end else begin
                        mem_error_nxt = 1'b1;
                        state_nxt     = DONE;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                // A late ack still completes the access, even on the timeout cycle.
                if (bus_ack) begin
                    if (bus_read)
                        memory_value_nxt = byte_q ? {24'h0, lane_byte} : bus_rdata;
                    bus_read_nxt  = 1'b0;
                    bus_write_nxt = 1'b0;
                    state_nxt     = DONE;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    bus_read_nxt     = 1'b0;
                    bus_write_nxt    = 1'b0;
                    memory_value_nxt = 32'h0;
                    mem_error_nxt    = 1'b1;
                    state_nxt        = DONE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (!nRst)
            stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state        <= IDLE;
            wait_cnt     <= 16'h0;
            byte_q       <= 1'b0;
            lane_q       <= 2'd0;
            bus_addr     <= 32'h0;
            bus_wdata    <= 32'h0;
            bus_sel      <= 4'h0;
            bus_read     <= 1'b0;
            bus_write    <= 1'b0;
            memory_value <= 32'h0;
            mem_error    <= 1'b0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_cnt_nxt;
            byte_q       <= byte_q_nxt;
            lane_q       <= lane_q_nxt;
            bus_addr     <= bus_addr_nxt;
            bus_wdata    <= bus_wdata_nxt;
            bus_sel      <= bus_sel_nxt;
            bus_read     <= bus_read_nxt;
            bus_write    <= bus_write_nxt;
            memory_value <= memory_value_nxt;
            mem_error    <= mem_error_nxt;
        end
    end
endmodule
